median_rd_sched: RTL

//  Read-side scheduler for the 9-bank median frame store. Tracks completed frame writes; once 9 frames are

---
 rtl/median_rd_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/median_rd_sched.sv
// Read-side scheduler for the 9-bank median frame store: sweeps all banks once NBANK frames are resident.
// Optional MEDSCHED_PERF_EN adds a saturating output stall counter (stall_cnt).
`timescale 1ns/1ps

module median_rd_sched #(
    parameter int NBANK   = 9,
    parameter int AW      = 10,
    parameter int DW      = 64,
    parameter int FRM_LEN = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frm_done,
    input  logic [3:0]          frm_bank,
    output logic [AW-1:0]       rd_addr,
    input  logic [NBANK*DW-1:0] rd_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NBANK*DW-1:0] out_data,
    output logic [AW-1:0]       out_addr,
    output logic                out_last,
    output logic                busy,
`ifdef MEDSCHED_PERF_EN
    output logic                overrun,
    output logic [15:0]         stall_cnt
`else
    output logic                overrun
`endif
);

    localparam logic [1:0]    IDLE      = 2'd0;
    localparam logic [1:0]    SWEEP     = 2'd1;
    localparam logic [1:0]    DRAIN     = 2'd2;
    localparam logic [1:0]    NCRED     = 2'd3;
    localparam logic [3:0]    NBANK4    = 4'(NBANK);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRM_LEN - 1);

    logic [1:0]          state;
    logic [3:0]          fill_cnt;
    logic [3:0]          fill_next;
    logic [3:0]          newest;
    logic [3:0]          pend_bank;
    logic                pending;
    logic                frm_valid;
    logic                sweep_start;
    logic [3:0]          start_bank;
    logic [1:0]          credits;
    logic                issue;
    logic                pop;
    logic                drain_done;
    logic                rd_vld_q;
    logic [AW-1:0]       rd_addr_q;
    logic [NBANK*DW-1:0] cap_data;
    logic [4:0]          tap_idx;
    logic [NBANK*DW-1:0] sk_data [2];
    logic [AW-1:0]       sk_addr [2];
    logic                sk_last [2];
    logic [1:0]          sk_cnt;
    logic [1:0]          sk_after;
    logic                load_out;
    logic                take_sk;
    logic                cap_to_out;
    logic                cap_to_sk;

    assign frm_valid   = frm_done && (frm_bank != 4'd0) && (frm_bank <= NBANK4);
    assign fill_next   = (frm_valid && fill_cnt != NBANK4) ? fill_cnt + 4'd1 : fill_cnt;
    assign sweep_start = (state == IDLE) && (pending || (frm_valid && fill_next == NBANK4));
    assign start_bank  = frm_valid ? frm_bank : pend_bank;
    assign busy        = (state != IDLE);
    assign issue       = (state == SWEEP) && (credits != 2'd0);
    assign pop         = out_valid && out_ready;
    // Every credit back home means no read in flight and nothing buffered.
    assign drain_done  = (state == DRAIN) && (({1'b0, credits} + {2'b0, pop}) == 3'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            fill_cnt  <= '0;
            newest    <= '0;
            pending   <= 1'b0;
            pend_bank <= '0;
            overrun   <= 1'b0;
        end else begin
            fill_cnt <= fill_next;
            overrun  <= frm_valid && busy;
            if (frm_valid && busy) begin
                pending   <= 1'b1;
                pend_bank <= frm_bank;
            end else if (sweep_start) begin
                pending <= 1'b0;
            end
            if (sweep_start)
                newest <= start_bank;
            case (state)
                IDLE:    if (sweep_start) state <= SWEEP;
                SWEEP:   if (issue && rd_addr == LAST_ADDR) state <= DRAIN;
                DRAIN:   if (drain_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            credits   <= NCRED;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            if (state == IDLE || drain_done)
                rd_addr <= '0;
            else if (issue && rd_addr != LAST_ADDR)
                rd_addr <= rd_addr + 1'b1;
            credits   <= credits - {1'b0, issue} + {1'b0, pop};
            rd_vld_q  <= issue;
            rd_addr_q <= rd_addr;
        end
    end

    // Tap k takes bank ((newest+k) mod NBANK)+1, i.e. word index (newest+k) mod NBANK.
    always_comb begin
        cap_data = '0;
        tap_idx  = '0;
        for (int k = 0; k < NBANK; k++) begin
            tap_idx = 5'(newest) + 5'(k);
            if (tap_idx >= 5'(NBANK))
                tap_idx = tap_idx - 5'(NBANK);
            cap_data[k*DW +: DW] = rd_data[int'(tap_idx)*DW +: DW];
        end
    end

    // Output register plus a 2-deep skid queue behind it form the 3-entry buffer.
    assign load_out   = !out_valid || pop;
    assign take_sk    = load_out && (sk_cnt != 2'd0);
    assign cap_to_out = load_out && (sk_cnt == 2'd0) && rd_vld_q;
    assign cap_to_sk  = rd_vld_q && !cap_to_out;
    assign sk_after   = sk_cnt - {1'b0, take_sk};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            sk_cnt    <= '0;
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
                sk_addr[i] <= '0;
                sk_last[i] <= 1'b0;
            end
        end else begin
            if (load_out) begin
                if (take_sk) begin
                    out_valid <= 1'b1;
                    out_data  <= sk_data[0];
                    out_addr  <= sk_addr[0];
                    out_last  <= sk_last[0];
                end else if (cap_to_out) begin
                    out_valid <= 1'b1;
                    out_data  <= cap_data;
                    out_addr  <= rd_addr_q;
                    out_last  <= (rd_addr_q == LAST_ADDR);
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (take_sk) begin
                sk_data[0] <= sk_data[1];
                sk_addr[0] <= sk_addr[1];
                sk_last[0] <= sk_last[1];
            end
            if (cap_to_sk) begin
                sk_data[sk_after[0]] <= cap_data;
                sk_addr[sk_after[0]] <= rd_addr_q;
                sk_last[sk_after[0]] <= (rd_addr_q == LAST_ADDR);
            end
            sk_cnt <= sk_after + {1'b0, cap_to_sk};
        end
    end

`ifdef MEDSCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (sweep_start)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
